// File: rtl/piso_serial_tx_pkg.sv
// Package for piso_serial_tx: pulls the shared state/line-level definitions
// into one importable scope.
package piso_serial_tx_pkg;
  `include "logic_defs.vh"
endpackage

// File: rtl/logic_defs.vh
// Shared state encodings and serial line levels for the PISO transmitter.
`ifndef LOGIC_DEFS_VH
`define LOGIC_DEFS_VH

localparam logic [2:0] S_IDLE   = 3'd0;
localparam logic [2:0] S_START  = 3'd1;
localparam logic [2:0] S_DATA   = 3'd2;
localparam logic [2:0] S_PARITY = 3'd3;
localparam logic [2:0] S_STOP   = 3'd4;

localparam logic LINE_IDLE = 1'b1;
localparam logic START_BIT = 1'b0;
localparam logic STOP_BIT  = 1'b1;

`endif

// File: rtl/piso_serial_tx_bit_tick.sv
// bit_tick_gen: bit-period timer; tick marks the last cycle of a bit period,
// pre_tick the cycle before it (never asserted when a bit is one cycle long).
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == CW'(CLKS_PER_BIT - 1));

  generate
    if (CLKS_PER_BIT > 1) begin : g_pre
      assign pre_tick = !clr && (cnt == CW'(CLKS_PER_BIT - 2));
    end else begin : g_no_pre
      assign pre_tick = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start(0), data LSB first, stop(1).
// Optional even-parity bit before stop when PISO_PARITY_EN is defined.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int   BCW     = $clog2(DATA_W) + 1;
  localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic [BCW-1:0]    bit_cnt;
  logic              tick;
  logic              pre_tick;
  logic              last_bit;
`ifdef PISO_PARITY_EN
  logic              parity;
`endif

  assign shreg_shift = shreg >> 1;
  assign last_bit    = (bit_cnt == BCW'(DATA_W - 1));

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == S_IDLE),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // tx_out is loaded with the level of the *next* cycle so the pin comes
  // straight from a flop; done likewise looks one cycle ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      tx_out   <= LINE_IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PISO_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= S_START;
            shreg    <= tx_data;
            bit_cnt  <= '0;
            tx_out   <= START_BIT;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef PISO_PARITY_EN
            parity   <= ^tx_data;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            state  <= S_DATA;
            tx_out <= shreg[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= shreg_shift;
            if (last_bit) begin
              bit_cnt <= '0;
`ifdef PISO_PARITY_EN
              state   <= S_PARITY;
              tx_out  <= parity;
`else
              state   <= S_STOP;
              tx_out  <= STOP_BIT;
              done    <= ONE_CLK;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shreg_shift[0];
            end
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state  <= S_STOP;
            tx_out <= STOP_BIT;
            done   <= ONE_CLK;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            state    <= S_IDLE;
            tx_out   <= LINE_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            done <= pre_tick;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_out   <= LINE_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: one instance at CLKS_PER_BIT=4, one at 1.
module tb_piso_serial_tx;
  localparam int DW = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic ready0, out0, busy0, done0;
  logic ready1, out1, busy1, done1;
  logic sel = 1'b0;
  logic m_ready, m_out, m_busy, m_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic exp_q[$];

  piso_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0),
    .tx_ready(ready0), .tx_out(out0), .busy(busy0), .done(done0)
  );

  piso_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
    .tx_ready(ready1), .tx_out(out1), .busy(busy1), .done(done1)
  );

  assign m_ready = sel ? ready1 : ready0;
  assign m_out   = sel ? out1   : out0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    if (sel) begin
      v1 = v; d1 = d;
    end else begin
      v0 = v; d0 = d;
    end
  endtask

  // Push the per-bit line levels of one frame for word w.
  task automatic expect_frame(input logic [DW-1:0] w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^w);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called at the negedge before the accepting posedge; checks every cycle.
  task automatic watch_frame(input string tag, input int cpb, input logic valid_after,
                             input logic [DW-1:0] data_after, output int start_cyc);
    logic cur;
    cur = 1'bx;
    start_cyc = 0;
    for (int k = 1; k <= NB * cpb; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_cyc = cyc;
        drive(valid_after, data_after);
      end
      if ((k - 1) % cpb == 0) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = 1'bx;
      end
      chk({tag, "_out"}, m_out, cur);
      chk({tag, "_done"}, m_done, (k == NB * cpb));
      chk({tag, "_busy"}, m_busy, 1'b1);
      chk({tag, "_ready"}, m_ready, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_end_ready"}, m_ready, 1'b1);
    chk({tag, "_end_busy"}, m_busy, 1'b0);
    chk({tag, "_end_done"}, m_done, 1'b0);
    chk({tag, "_end_out"}, m_out, 1'b1);
  endtask

  initial begin
    int s0, s1, cnt_done, cnt_low;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_out", out0, 1'b1);
    chk("rst_ready", ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst1_out", out1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: checked idle outputs");

    // Single frame 0xA5, producer changes data after accept.
    sel = 1'b0;
    drive(1'b1, 8'hA5);
    expect_frame(8'hA5);
    watch_frame("a5", 4, 1'b0, 8'h3C, s0);
    $display("frame 0xA5 at cpb=4 done");

    // Back-to-back 0x00 then 0xFF with tx_valid held high throughout.
    drive(1'b1, 8'h00);
    expect_frame(8'h00);
    watch_frame("b2b0", 4, 1'b1, 8'hFF, s0);
    expect_frame(8'hFF);
    watch_frame("b2b1", 4, 1'b0, 8'h5A, s1);
    chk("b2b_spacing", s1 - s0, NB * 4 + 1);
    $display("back-to-back 0x00/0xFF spacing=%0d", s1 - s0);

    // Reset during the third data bit of 0x3C.
    drive(1'b1, 8'h3C);
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (13) @(negedge clk);
    chk("mid_busy", busy0, 1'b1);
    chk("mid_out_bit2", out0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", out0, 1'b1);
    chk("mid_rst_ready", ready0, 1'b1);
    chk("mid_rst_busy", busy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    cnt_low = 0;
    repeat (NB * 4) begin
      @(negedge clk);
      if (done0) cnt_done++;
      if (!out0) cnt_low++;
    end
    chk("mid_no_done", cnt_done, 0);
    chk("mid_line_idle", cnt_low, 0);
    drive(1'b1, 8'h81);
    expect_frame(8'h81);
    watch_frame("after_rst81", 4, 1'b0, 8'h00, s0);
    $display("reset mid-frame then 0x81 done");

    // One clock per bit.
    sel = 1'b1;
    drive(1'b1, 8'h01);
    expect_frame(8'h01);
    watch_frame("cpb1", 1, 1'b0, 8'hFE, s0);
    $display("frame 0x01 at cpb=1 done");

    // Parity-sensitive words (parity bit present only in the parity build).
    sel = 1'b0;
    drive(1'b1, 8'h07);
    expect_frame(8'h07);
    watch_frame("w07", 4, 1'b0, 8'h00, s0);
    drive(1'b1, 8'hA5);
    expect_frame(8'hA5);
    watch_frame("wa5", 4, 1'b0, 8'h00, s0);
    $display("frames 0x07/0xA5 done");

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
